dsp_mac_sequencer: RTL
======================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 Parameter N_TAPS, default 8, SHALL set the number of products per frame (legal 1..1024).
REQ-002 Parameter DSP_LATENCY, default 3, SHALL set the cycles from A/B presentation to P update in the downstream DSP.
REQ-003 Parameter OPM_SKEW, default 1, SHALL set the cycles OPMODE_OUT lags the A/B beat it belongs to.
REQ-004 Parameter RND_SHIFT, default 4, SHALL set the rounding shift (used only under Configuration).
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Port names SHALL be CLK and RSTN.
REQ-006 CLK  in  1  rising-edge clock for all state.
REQ-007 RSTN  in  1  asynchronous active-low reset.
REQ-008 IN_VALID  in  1  sample pair offered.
REQ-009 IN_READY  out  1  sequencer accepts the offered pair.
REQ-010 IN_A, IN_B  in  18 each  signed operands.
REQ-011 A_OUT, B_OUT  out  18 each  operands to DSP A/B ports.
REQ-012 C_OUT  out  48  DSP C port.
REQ-013 OPMODE_OUT  out  8  DSP OPMODE.
REQ-014 CE_OUT  out  1  drives all DSP clock enables.
REQ-015 DSP_P  in  48  DSP P result.
REQ-016 DSP_CARRYOUT  in  1  DSP carry-out.
REQ-017 OUT_VALID  out  1  result available.
REQ-018 OUT_READY  in  1  consumer accepts result.
REQ-019 OUT_P  out  48  frame result.
REQ-020 OUT_CARRY  out  1  sticky OR of DSP_CARRYOUT over the frame.

Function
REQ-021 FSM states SHALL be IDLE, ACCUM, DRAIN, HOLD; IDLE->ACCUM on first accepted pair; ACCUM->DRAIN on N_TAPS-th accept; DRAIN->HOLD after DSP_LATENCY cycles; HOLD->IDLE on OUT_VALID&&OUT_READY.
REQ-022 IN_READY SHALL be 1 in IDLE and in ACCUM, 0 in DRAIN and HOLD; accept = IN_VALID&&IN_READY.
REQ-023 On accept, A_OUT/B_OUT SHALL register IN_A/IN_B; on any non-accept cycle they SHALL register 0 (bubble).
REQ-024 Beat opcode SHALL be 8'h01 (X=M, Z=0) for the frame's first pair and 8'h09 (X=M, Z=P) for all other pairs, bubbles and idle cycles.
REQ-025 OPMODE_OUT SHALL be the beat opcode delayed OPM_SKEW cycles through a shift register reset to 8'h09.
REQ-026 CE_OUT SHALL be 1 whenever RSTN is high.
REQ-027 DRAIN SHALL count DSP_LATENCY cycles after the last accept edge; on the following edge OUT_P SHALL capture DSP_P and OUT_VALID SHALL rise (latency DSP_LATENCY+1 from last accept).
REQ-028 OUT_P and OUT_CARRY SHALL stay stable in HOLD while OUT_READY is low.
REQ-029 OUT_CARRY SHALL clear on the first accept of a frame and OR in DSP_CARRYOUT every cycle until capture.
REQ-030 Frame counter SHALL be ceil(log2(N_TAPS+1)) bits and SHALL reset to 0 on each frame start; N_TAPS=1 SHALL go ACCUM->DRAIN on the same accept that leaves IDLE.
REQ-031 Bubbles in ACCUM SHALL not change the accumulated sum.

Reset
REQ-032 RSTN low SHALL immediately force IDLE, counters 0, A_OUT/B_OUT/C_OUT/OUT_P 0, OUT_VALID/OUT_CARRY 0, CE_OUT 0, OPMODE_OUT 8'h09.
REQ-033 Reset mid-frame SHALL discard the partial frame; the next accepted pair after release SHALL start a new frame.

Configuration
REQ-034 With MAC_SEQ_ROUND_EN defined, first-pair opcode SHALL be 8'h0D (Z=C), C_OUT SHALL be constant 1<<(RND_SHIFT-1), and OUT_P SHALL be DSP_P arithmetically shifted right by RND_SHIFT.
REQ-035 Without MAC_SEQ_ROUND_EN, C_OUT SHALL be 0, first-pair opcode 8'h01, OUT_P = DSP_P unshifted.

Verification (bench uses behavioural DSP model, latency 3, N_TAPS=4)
REQ-036 Pairs (1,2),(3,4),(5,6),(7,8) back-to-back, OUT_READY=1 -> OUT_P=48'h64, OUT_VALID 4 cycles after last accept, OUT_CARRY=0.
REQ-037 Same pairs with IN_VALID low 3 cycles between pairs 2 and 3 -> OUT_P=48'h64.
REQ-038 Pairs (-3,5),(0,0),(0,0),(0,0) -> OUT_P=48'hFFFF_FFFF_FFF1.
REQ-039 OUT_READY low 5 cycles after OUT_VALID -> OUT_P held 48'h64, IN_READY=0 throughout, IDLE on sixth cycle.
REQ-040 RSTN low after 2 accepts, then full frame of REQ-036 -> OUT_P=48'h64, no stale contribution.
REQ-041 MAC_SEQ_ROUND_EN defined, RND_SHIFT=4, REQ-036 pairs -> OUT_P=48'h6 ((100+8)>>4).

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// Sequences signed 18x18 operand pairs into an external DSP MAC slice and captures one result per frame.
// Define MAC_SEQ_ROUND_EN to preload the round constant via C and return DSP_P >>> RND_SHIFT.
//   state | meaning
//   IDLE  | waiting for the first pair of a frame
//   ACCUM | accepting the remaining pairs of the frame
//   DRAIN | waiting out the DSP pipeline after the last pair
//   HOLD  | result presented until the consumer takes it
module dsp_mac_sequencer #(
    parameter int N_TAPS      = 8,
    parameter int DSP_LATENCY = 3,
    parameter int OPM_SKEW    = 1,
    parameter int RND_SHIFT   = 4
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic signed [17:0] IN_A,
    input  logic signed [17:0] IN_B,
    output logic signed [17:0] A_OUT,
    output logic signed [17:0] B_OUT,
    output logic        [47:0] C_OUT,
    output logic        [7:0]  OPMODE_OUT,
    output logic               CE_OUT,
    input  logic        [47:0] DSP_P,
    input  logic               DSP_CARRYOUT,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic        [47:0] OUT_P,
    output logic               OUT_CARRY
);

    localparam int FCW = $clog2(N_TAPS + 1);
    localparam int DCW = (DSP_LATENCY < 1) ? 1 : $clog2(DSP_LATENCY + 1);
    localparam logic [FCW-1:0] LAST_CNT = FCW'(N_TAPS - 1);
    localparam logic [DCW-1:0] DRAIN_LD = DCW'(DSP_LATENCY);
    localparam logic [7:0]     OP_ACC   = 8'h09;

`ifdef MAC_SEQ_ROUND_EN
    localparam logic [7:0]  OP_FIRST = 8'h0D;
    localparam logic [47:0] C_CONST  = 48'd1 << (RND_SHIFT - 1);
`else
    localparam logic [7:0]  OP_FIRST = 8'h01;
    localparam logic [47:0] C_CONST  = 48'd0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

    state_t             state_q;
    logic [FCW-1:0]     frame_cnt_q;
    logic [DCW-1:0]     drain_cnt_q;
    logic signed [17:0] a_q, b_q;
    logic [47:0]        c_q;
    logic [7:0]         beat_op_q;
    logic [47:0]        p_q;
    logic               valid_q;
    logic               carry_q;

    logic               accept;
    logic [7:0]         beat_op_d;
    logic [47:0]        p_cap_d;

    assign IN_READY  = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign accept    = IN_VALID && IN_READY;
    assign beat_op_d = (accept && state_q == S_IDLE) ? OP_FIRST : OP_ACC;

`ifdef MAC_SEQ_ROUND_EN
    assign p_cap_d = $signed(DSP_P) >>> RND_SHIFT;
`else
    assign p_cap_d = DSP_P;
`endif

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            drain_cnt_q <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            beat_op_q   <= OP_ACC;
            p_q         <= '0;
            valid_q     <= 1'b0;
            carry_q     <= 1'b0;
        end else begin
            // Non-accept cycles feed zero operands so the running sum is untouched.
            a_q       <= accept ? IN_A : '0;
            b_q       <= accept ? IN_B : '0;
            c_q       <= C_CONST;
            beat_op_q <= beat_op_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        carry_q     <= 1'b0;
                        frame_cnt_q <= FCW'(1);
                        if (N_TAPS == 1) begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= DRAIN_LD;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    carry_q <= carry_q | DSP_CARRYOUT;
                    if (accept) begin
                        frame_cnt_q <= frame_cnt_q + FCW'(1);
                        if (frame_cnt_q == LAST_CNT) begin
                            state_q     <= S_DRAIN;
                            drain_cnt_q <= DRAIN_LD;
                        end
                    end
                end
                S_DRAIN: begin
                    carry_q <= carry_q | DSP_CARRYOUT;
                    if (drain_cnt_q == '0) begin
                        p_q     <= p_cap_d;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - DCW'(1);
                    end
                end
                S_HOLD: begin
                    if (OUT_READY) begin
                        valid_q     <= 1'b0;
                        frame_cnt_q <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // OPMODE trails its A/B beat by OPM_SKEW cycles to meet the DSP's internal OPMODE register stage.
    generate
        if (OPM_SKEW == 0) begin : g_no_skew
            assign OPMODE_OUT = beat_op_q;
        end else begin : g_skew
            logic [7:0] opm_sr_q [OPM_SKEW];
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    for (int i = 0; i < OPM_SKEW; i++) opm_sr_q[i] <= OP_ACC;
                end else begin
                    opm_sr_q[0] <= beat_op_q;
                    for (int i = 1; i < OPM_SKEW; i++) opm_sr_q[i] <= opm_sr_q[i-1];
                end
            end
            assign OPMODE_OUT = opm_sr_q[OPM_SKEW-1];
        end
    endgenerate

    assign A_OUT     = a_q;
    assign B_OUT     = b_q;
    assign C_OUT     = c_q;
    assign CE_OUT    = RSTN;
    assign OUT_VALID = valid_q;
    assign OUT_P     = p_q;
    assign OUT_CARRY = carry_q;

endmodule
